// File: rtl/rob_banked_if.sv
// rob_banked_if: bus bundle between the banked reorder buffer and its neighbours.
//   master : rename/dispatch + execute writeback side (drives disp_*, wb_*)
//   slave  : the reorder buffer (drives disp_ready/disp_row, commit_*, squash_*, status)
// Ports (per slot / per writeback port, BANKS wide):
//   disp_valid, disp_is_br, disp_phys_rd, disp_arch_rd, disp_pc  -> dispatch row payload
//   disp_ready, disp_row                                          <- row accept / row index
//   wb_valid, wb_row, wb_bank, wb_is_br, wb_mispred               -> writeback / branch resolve
//   commit_valid, commit_phys_rd, commit_arch_rd, commit_pc       <- oldest row retiring
//   squash_valid, squash_head                                     <- mispredict recovery
//   count, empty, full                                            <- occupancy
interface rob_banked_if #(
  parameter int BANKS  = 2,
  parameter int DEPTH  = 16,
  parameter int PHYS_W = 6
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic [BANKS-1:0]             disp_valid;
  logic [BANKS-1:0]             disp_is_br;
  logic [BANKS-1:0][PHYS_W-1:0] disp_phys_rd;
  logic [BANKS-1:0][4:0]        disp_arch_rd;
  logic [BANKS-1:0][31:0]       disp_pc;
  logic                         disp_ready;
  logic [AW-1:0]                disp_row;

  logic [BANKS-1:0]             wb_valid;
  logic [BANKS-1:0][AW-1:0]     wb_row;
  logic [BANKS-1:0][BW-1:0]     wb_bank;
  logic [BANKS-1:0]             wb_is_br;
  logic [BANKS-1:0]             wb_mispred;

  logic [BANKS-1:0]             commit_valid;
  logic [BANKS-1:0][PHYS_W-1:0] commit_phys_rd;
  logic [BANKS-1:0][4:0]        commit_arch_rd;
  logic [BANKS-1:0][31:0]       commit_pc;

  logic                         squash_valid;
  logic [AW-1:0]                squash_head;
  logic [AW:0]                  count;
  logic                         empty;
  logic                         full;

  modport master (
    output disp_valid, disp_is_br, disp_phys_rd, disp_arch_rd, disp_pc,
    output wb_valid, wb_row, wb_bank, wb_is_br, wb_mispred,
    input  disp_ready, disp_row,
    input  commit_valid, commit_phys_rd, commit_arch_rd, commit_pc,
    input  squash_valid, squash_head, count, empty, full
  );

  modport slave (
    input  disp_valid, disp_is_br, disp_phys_rd, disp_arch_rd, disp_pc,
    input  wb_valid, wb_row, wb_bank, wb_is_br, wb_mispred,
    output disp_ready, disp_row,
    output commit_valid, commit_phys_rd, commit_arch_rd, commit_pc,
    output squash_valid, squash_head, count, empty, full
  );
endinterface

// File: rtl/rob_banked.sv
// rob_banked: banked reorder buffer. DEPTH rows of BANKS slots in program order;
// a mispredicted branch squashes only younger rows/slots, keeping the branch row.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   rob    : rob_banked_if.slave bundle (dispatch, writeback, commit, squash, status)
module rob_banked #(
  parameter int BANKS  = 2,
  parameter int DEPTH  = 16,
  parameter int PHYS_W = 6,
  parameter int MAX_BR = 4
) (
  input logic         clk,
  input logic         rst_n,
  rob_banked_if.slave rob
);
  localparam int AW   = $clog2(DEPTH);
  localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int CW   = $clog2(DEPTH * BANKS + 1);
  localparam int CNTW = AW + 1;

  // Per-slot state and payload storage
  logic [BANKS-1:0]             valid_reg   [DEPTH];
  logic [BANKS-1:0]             done_reg    [DEPTH];
  logic [BANKS-1:0]             pend_br_reg [DEPTH];
  logic [BANKS-1:0][PHYS_W-1:0] phys_mem    [DEPTH];
  logic [BANKS-1:0][4:0]        arch_mem    [DEPTH];
  logic [BANKS-1:0][31:0]       pc_mem      [DEPTH];

  logic [AW-1:0]   head_reg;
  logic [AW-1:0]   tail_reg;
  logic [CNTW-1:0] count_reg;

  // Age relative to the oldest row; all age compares are unsigned in AW bits
  logic [AW-1:0] row_age [DEPTH];
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    assign row_age[gi] = AW'(gi) - tail_reg;
  end

  // Per writeback port: target age and mispredict candidacy (valid target only)
  logic [AW-1:0] wb_age   [BANKS];
  logic          mis_cand [BANKS];
  for (genvar gi = 0; gi < BANKS; gi++) begin : g_port
    assign wb_age[gi]   = rob.wb_row[gi] - tail_reg;
    assign mis_cand[gi] = rob.wb_valid[gi] & rob.wb_is_br[gi] & rob.wb_mispred[gi] &
                          (|(valid_reg[rob.wb_row[gi]] & (BANKS'(1) << rob.wb_bank[gi])));
  end

  logic [CW-1:0] br_cnt;
  always_comb begin
    br_cnt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int b = 0; b < BANKS; b++) begin
        br_cnt = br_cnt + CW'(pend_br_reg[r][b]);
      end
    end
  end

  // Oldest mispredict wins: lowest age, then lowest bank
  logic          br_found;
  logic [AW-1:0] br_row;
  logic [AW-1:0] br_age;
  logic [BW-1:0] br_bank;
  always_comb begin
    br_found = 1'b0;
    br_row   = '0;
    br_age   = '0;
    br_bank  = '0;
    for (int p = 0; p < BANKS; p++) begin
      if (mis_cand[p] && (!br_found || (wb_age[p] < br_age) ||
          ((wb_age[p] == br_age) && (rob.wb_bank[p] < br_bank)))) begin
        br_found = 1'b1;
        br_row   = rob.wb_row[p];
        br_age   = wb_age[p];
        br_bank  = rob.wb_bank[p];
      end
    end
  end

  logic full_w;
  logic commit_fire;
  logic disp_ready_w;
  logic disp_accept;
  assign full_w       = (count_reg == CNTW'(DEPTH));
  assign commit_fire  = (count_reg != '0) &&
                        ((valid_reg[tail_reg] & ~done_reg[tail_reg]) == '0);
  assign disp_ready_w = !full_w && !br_found &&
                        !((|rob.disp_is_br) && (br_cnt >= CW'(MAX_BR)));
  assign disp_accept  = disp_ready_w && (|rob.disp_valid);

  // Squash mask and writeback hits; a squashed or invalid target is ignored
  logic [BANKS-1:0] kill   [DEPTH];
  logic [BANKS-1:0] wb_set [DEPTH];
  logic [BANKS-1:0] wb_clr [DEPTH];
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      kill[r]   = '0;
      wb_set[r] = '0;
      wb_clr[r] = '0;
      for (int b = 0; b < BANKS; b++) begin
        kill[r][b] = br_found && ((row_age[r] > br_age) ||
                     ((AW'(r) == br_row) && (BW'(b) > br_bank)));
        for (int p = 0; p < BANKS; p++) begin
          if (rob.wb_valid[p] && (rob.wb_row[p] == AW'(r)) && (rob.wb_bank[p] == BW'(b))) begin
            wb_set[r][b] = 1'b1;
            if (rob.wb_is_br[p]) wb_clr[r][b] = 1'b1;
          end
        end
      end
      wb_set[r] = wb_set[r] & valid_reg[r] & ~kill[r];
      wb_clr[r] = wb_clr[r] & valid_reg[r] & ~kill[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        valid_reg[r]   <= '0;
        done_reg[r]    <= '0;
        pend_br_reg[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        // Commit clearing wins over same-cycle writeback into the retiring row
        if (commit_fire && (AW'(r) == tail_reg)) begin
          valid_reg[r]   <= '0;
          done_reg[r]    <= '0;
          pend_br_reg[r] <= '0;
        end else if (disp_accept && (AW'(r) == head_reg)) begin
          valid_reg[r]   <= rob.disp_valid;
          done_reg[r]    <= '0;
          pend_br_reg[r] <= rob.disp_valid & rob.disp_is_br;
        end else begin
          valid_reg[r]   <= valid_reg[r] & ~kill[r];
          done_reg[r]    <= (done_reg[r] | wb_set[r]) & ~kill[r];
          pend_br_reg[r] <= pend_br_reg[r] & ~wb_clr[r] & ~kill[r];
        end
      end
      tail_reg <= tail_reg + AW'(commit_fire);
      if (br_found) begin
        head_reg  <= br_row + AW'(1);
        count_reg <= CNTW'(br_age) + CNTW'(1) - CNTW'(commit_fire);
      end else begin
        head_reg  <= head_reg + AW'(disp_accept);
        count_reg <= count_reg + CNTW'(disp_accept) - CNTW'(commit_fire);
      end
    end
  end

  // Payload storage needs no reset: it is only observed through valid slots
  always_ff @(posedge clk) begin
    if (disp_accept) begin
      phys_mem[head_reg] <= rob.disp_phys_rd;
      arch_mem[head_reg] <= rob.disp_arch_rd;
      pc_mem[head_reg]   <= rob.disp_pc;
    end
  end

  assign rob.disp_ready     = disp_ready_w;
  assign rob.disp_row       = head_reg;
  assign rob.commit_valid   = {BANKS{commit_fire}} & valid_reg[tail_reg];
  assign rob.commit_phys_rd = phys_mem[tail_reg];
  assign rob.commit_arch_rd = arch_mem[tail_reg];
  assign rob.commit_pc      = pc_mem[tail_reg];
  assign rob.squash_valid   = br_found;
  assign rob.squash_head    = br_row + AW'(1);
  assign rob.count          = count_reg;
  assign rob.empty          = (count_reg == '0);
  assign rob.full           = full_w;
endmodule

// File: doc/rob_banked.md
# rob_banked

Parametrised banked reorder buffer: the successor to the fixed two-bank ROB.
- It tracks up to DEPTH rows of BANKS instruction slots in program order, with any bank count and multiple outstanding branches.
- On a mispredicted branch it squashes only the rows and slots younger than that branch. The branch row and all older work are retained, so no full pipeline flush is needed.
- It sits between rename/dispatch, the execute writeback buses and the commit stage (free list / arch map update).

## Interface
Parameters:
- BANKS, 2, slots per row (≥1)
- DEPTH, 16, rows; power of two, ≥4; AW = log2(DEPTH), BW = max(1, log2(BANKS))
- PHYS_W, 6, physical register index width
- MAX_BR, 4, maximum unresolved branches held (≤DEPTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset synchronous active-low
- disp_valid  in  BANKS  per-slot dispatch request for the current row
- disp_is_br  in  BANKS  slot is a branch; at most one set per row, and it must be the highest valid bank
- disp_phys_rd / disp_arch_rd / disp_pc  in  BANKS×PHYS_W / BANKS×5 / BANKS×32  per-slot payload
- disp_ready  out  1  row accepted this cycle if any disp_valid bit is set
- disp_row  out  AW  row index assigned (current head)
- wb_valid  in  BANKS  writeback ports (port index ≠ bank)
- wb_row / wb_bank  in  BANKS×AW / BANKS×BW  target slot
- wb_is_br / wb_mispred  in  BANKS / BANKS  branch resolved / resolved as mispredicted
- commit_valid  out  BANKS  slot committing this cycle
- commit_phys_rd / commit_arch_rd / commit_pc  out  per-slot payload
- squash_valid  out  1  a mispredict was taken this cycle
- squash_head  out  AW  new head (branch row + 1, mod DEPTH)
- count  out  AW+1  occupied rows
- empty / full  out  1  count==0 / count==DEPTH

## Operation
- **State.**
  - Circular rows; each slot holds valid, done, pend_br, phys_rd, arch_rd, pc.
  - Pointers: head (next dispatch), tail (oldest). count is AW+1 bits, so full and empty are distinct.
  - Age of row r = (r − tail) mod DEPTH.
- **Branch count.** br_cnt = popcount of pend_br over all slots.
- **Dispatch.**
  - disp_ready = !full && !squash_valid && !(|disp_is_br && br_cnt==MAX_BR).
  - On accept, row head is written: valid=disp_valid, done=0, pend_br=disp_valid&disp_is_br. Then head+1 and count+1.
  - A row with all disp_valid=0 is not accepted and head does not advance.
- **Writeback.**
  - Each wb_valid port whose target slot is valid sets done.
  - If wb_is_br, the port also clears pend_br.
  - A target slot that is invalid, or is squashed in the same cycle, is ignored.
- **Mispredict.**
  - Among wb ports with wb_valid&wb_is_br&wb_mispred on valid slots, the oldest wins: lowest row age, then lowest bank.
  - squash_valid=1 and squash_head=br_row+1.
  - At the edge:
    - all slots in rows of age > age(br_row) are cleared (valid, done, pend_br = 0);
    - slots in br_row with bank > br_bank are cleared;
    - head ← br_row+1;
    - count ← age(br_row)+1 − commit_fire.
  - Younger mispredicts in the same cycle are discarded. Older correct-branch and non-branch writebacks in the same cycle still apply.
- **Commit.**
  - commit_fire = !empty && every valid slot of row tail has done=1.
  - commit_valid[b] = commit_fire & valid[tail][b]; payload comes from row tail (combinational).
  - At the edge: row tail is cleared, then tail+1 and count−1.
  - A row whose done bits are set in the same cycle commits no earlier than the next cycle.
- **Simultaneous events.**
  - Dispatch and commit in the same cycle leave count unchanged.
  - A mispredict in the tail row while that row commits: the row commits, head=tail+1, and count becomes 0.
- **Reset.**
  - All slots cleared; head=tail=0, count=0.
  - Outputs: disp_ready=1, empty=1, full=0, commit_valid=0, squash_valid=0, disp_row=0, squash_head=1.
  - Reset asserted mid-operation discards all contents at that edge, with no commit output.

## Timing
- Dispatch accepted at edge N: the row is visible (count, wb target) from N+1.
- Writeback at edge N: the row may commit (commit_valid high) in cycle N+1 at the earliest.
- Latency from dispatch to commit is at least 2 cycles.
- squash_valid is combinational from the wb inputs in the same cycle. disp_ready is low in that cycle; dispatch may resume in the next cycle, into row squash_head.
- commit_* are combinational from state only (no input paths). disp_ready depends on wb_* only via squash_valid.
- Wrap-around: head, tail and squash_head wrap mod DEPTH. Age arithmetic is in AW bits, unsigned.

## Test plan
- **Fill/drain.** Reset, then dispatch 16 rows (BANKS=2, all slots valid) → full=1 after the 16th, disp_ready=0. Writeback row 0 both banks → commit_valid=2'b11 next cycle, then count=15 and disp_ready=1.
- **Partial row.** Dispatch disp_valid=2'b01, writeback bank0 → commit_valid=2'b01 with no wait on bank1. Writeback to row 0 bank1 → ignored, no commit.
- **Mispredict.**
  - Setup: tail=0, rows 0–5 dispatched; branch at row 2 bank0, with bank1 invalid.
  - Stimulus: wb mispred row 2.
  - Response: squash_valid=1, squash_head=3, count=3 next cycle. Next dispatch gets disp_row=3. Writebacks to rows 3–5 are ignored.
- **Two mispredicts, one cycle.** Branches in rows 1 and 4 mispredict simultaneously → row 1 wins, head=2, and row 4's pend_br is cleared.
- **MAX_BR stall, wrap, commit+squash.**
  - With 4 pending branches, a branch row → disp_ready=0 while a non-branch row is accepted; resolving one branch restores acceptance.
  - With tail=14, dispatch 4 rows → head=2, count=4.
  - Mispredict in the tail row while it commits → count=0, empty=1.
- **Reset mid-run.** With count=7 and rst_n=0 for one edge → count=0, empty=1, commit_valid=0, disp_row=0.
